// File: rtl/fp32_pkg.sv
// Shared definitions for the binary32 add/subtract datapath back-end.
package fp32_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_INF  = 255;

  localparam int SIGN_W = 1;
  localparam int EXPF_W = 8;
  localparam int FRAC_W = 23;

  // Internal signed exponent width; holds biased exponents -26..256.
  localparam int EXP_W  = 10;
  // Mantissa: [27] carry, [26] hidden, [25:3] fraction, [2:0] guard/round/sticky.
  localparam int MANT_W = 28;

  localparam logic signed [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_ZERO  = '0;
  localparam logic signed [EXP_W-1:0] EXP_INF_S = EXP_W'(EXP_INF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a normalized 28-bit mantissa.
// Bits [2:0] are guard/round/sticky; a rounding carry out of the 24-bit
// significand renormalizes it by one right shift and bumps the exponent.
module fp_round_rne
  import fp32_pkg::*;
(
  input  logic        [MANT_W-1:0] i_mant,
  input  logic signed [EXP_W-1:0]  i_exp,
  output logic        [23:0]       o_sig,
  output logic signed [EXP_W-1:0]  o_exp,
  output logic                     o_carry
);

  logic        w_inc;
  logic [24:0] w_sum;

  // Round up when guard is set and any of round, sticky or the LSB is set.
  assign w_inc = i_mant[2] & (i_mant[1] | i_mant[0] | i_mant[3]);

  // Bit 27 sits in the carry position of the sum, so a stray carry bit
  // behaves like a rounding carry rather than being silently dropped.
  assign w_sum   = {i_mant[27], i_mant[26:3]} + {24'd0, w_inc};
  assign o_carry = w_sum[24];
  assign o_sig   = o_carry ? w_sum[24:1] : w_sum[23:0];
  assign o_exp   = o_carry ? (i_exp + EXP_ONE) : i_exp;

endmodule

// File: rtl/fp32_normalize_pack.sv
// Normalize/round/pack back-end: takes an unpacked sum and emits a packed
// binary32 with an overflow/underflow exception flag. One job in flight.
// Handshake: a transfer happens on a rising edge where valid & ready are
// both 1; a producer holds valid and its data until that edge, and the
// result side holds out_valid, res and exception stable until accepted.
module fp32_normalize_pack
  import fp32_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic signed [EXP_W-1:0]  in_exp,
  input  logic        [MANT_W-1:0] in_mant,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [31:0]       res,
  output logic                     exception,
  output state_t                   dbg_state
);

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_sign;
  logic signed [EXP_W-1:0] r_exp;
  logic [MANT_W-1:0]       r_mant;
  logic [31:0]             r_res;
  logic                    r_exc;

  logic [23:0]             w_rnd_sig;
  logic signed [EXP_W-1:0] w_rnd_exp;
  logic                    w_rnd_carry;
  logic                    w_mant_zero;

  assign w_mant_zero = (r_mant == '0);

  fp_round_rne u_round (
    .i_mant  (r_mant),
    .i_exp   (r_exp),
    .o_sig   (w_rnd_sig),
    .o_exp   (w_rnd_exp),
    .o_carry (w_rnd_carry)
  );

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: NORM exits on zero (straight to DONE) or once the carry or
  // hidden bit is set; otherwise it keeps shifting left.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = NORM;
      NORM: begin
        if (w_mant_zero)                  w_next = DONE;
        else if (r_mant[27] | r_mant[26]) w_next = ROUND;
        else                              w_next = NORM;
      end
      ROUND:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture, one shift per NORM cycle, then round and pack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_mant <= '0;
      r_res  <= '0;
      r_exc  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= in_sign;
            r_exp  <= in_exp;
            r_mant <= in_mant;
          end
        end
        NORM: begin
          if (w_mant_zero) begin
            r_res <= {r_sign, 31'b0};
            r_exc <= 1'b0;
          end else if (r_mant[27]) begin
            // Bits shifted out of the sticky position are ORed back in.
            r_mant <= {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
            r_exp  <= r_exp + EXP_ONE;
          end else if (!r_mant[26]) begin
            // Sticky stays in place so a left shift never clears it.
            r_mant <= {r_mant[26:0], 1'b0} | {{(MANT_W-1){1'b0}}, r_mant[0]};
            r_exp  <= r_exp - EXP_ONE;
          end
        end
        ROUND: begin
          if (w_rnd_exp >= EXP_INF_S) begin
            r_res <= {r_sign, 8'hFF, 23'b0};
            r_exc <= 1'b1;
          end else if ((w_rnd_exp <= EXP_ZERO) || !w_rnd_sig[23]) begin
            // Denormal range is flushed to signed zero.
            r_res <= {r_sign, 31'b0};
            r_exc <= 1'b1;
          end else begin
            r_res <= {r_sign, w_rnd_exp[EXPF_W-1:0], w_rnd_sig[FRAC_W-1:0]};
            r_exc <= 1'b0;
          end
          if (w_rnd_carry) begin
            r_mant <= {1'b0, w_rnd_sig, 3'b000};
            r_exp  <= w_rnd_exp;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign res       = r_res;
  assign exception = r_exc;
  assign dbg_state = r_state;

endmodule

// File: doc/fp32_normalize_pack.md
# fp32_normalize_pack

Multi-cycle normalize/round/pack back-end for the single-precision add/subtract datapath. Accepts an unpacked sum (sign, wide signed exponent, mantissa with carry, hidden, guard, round and sticky bits) and produces a packed IEEE-754 binary32 result with an exception flag. Unpacking is the front of the datapath; this block closes it. One left shift per cycle; valid/ready on both sides.

## Interface
- EXP_W, 10: internal signed exponent width. Must hold biased exponent range −26..256.
- MANT_W, 28: input mantissa width.
  - Bit 27 is carry, bit 26 is hidden.
  - Bits 25:3 are fraction; bits 2:0 are guard, round, sticky.
- clk  in  1  clock. All state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input job present.
- in_ready  out  1  block can accept a job.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  signed biased exponent of the input mantissa, hidden bit at bit 26.
- in_mant  in  MANT_W  unnormalized magnitude.
- out_valid  out  1  res/exception valid.
- out_ready  in  1  consumer accepts result.
- res  out  32  packed binary32.
- exception  out  1  overflow to ±inf or underflow flushed to ±0.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, capture sign, exp, mant; go to NORM.
  - NORM, evaluated in this priority each cycle:
    - mant==0: res={sign,31'b0}, exception=0, go to DONE.
    - mant[27]=1: shift right 1, sticky |= shifted-out bit, exp+1, go to ROUND.
    - mant[26]=1: go to ROUND.
    - Otherwise: shift left 1, exp−1, stay in NORM.
  - ROUND: round-to-nearest-even on bits 2:0.
    - Increment when G & (R|S|LSB), where LSB is mant[3].
    - If the increment carries into bit 27, shift right 1 and exp+1, in the same cycle.
    - Then range-check:
      - exp≥255: res={sign,8'hFF,23'b0}, exception=1.
      - exp≤0: res={sign,31'b0}, exception=1. Denormals are flushed to zero.
      - Otherwise: res={sign,exp[7:0],mant[25:3]}, exception=0.
    - Go to DONE.
  - DONE: out_valid=1. res and exception are held stable until out_ready=1, then go to IDLE.
- in_ready is 1 only in IDLE. One job in flight; no overlap.
- Sticky is sticky: once set it is never cleared by later shifts of the same job.
- Exponent arithmetic is signed EXP_W bits and never wraps within the specified input range.
- Reset mid-operation aborts the job. The state returns to IDLE and no output is produced.

## Timing
- Reset values: in_ready=1 after the reset cycle; out_valid=0, res=0, exception=0.
- Let edge E0 be the edge on which in_valid & in_ready.
- L is the number of left shifts (0 if normalized or carry set).
- NORM occupies L+1 cycles; ROUND takes 1 cycle.
- out_valid rises 3+L edges after E0. Zero input: 2 edges.
- Worst case L=26 gives a latency of 29.
- Output accepted on edge Ek (out_valid & out_ready): in_ready=1 on the following cycle. The next job can be captured at Ek+1.
- out_ready held low indefinitely: out_valid stays 1; res and exception do not change.

## Structure
- Shared package fp32_pkg holds:
  - EXP_BIAS=127, EXP_INF=255.
  - Field widths: SIGN 1, EXP 8, FRAC 23.
  - EXP_W and MANT_W.
  - The state enum {IDLE, NORM, ROUND, DONE}.
- One sub-module: fp_round_rne. It is purely combinational.
  - Inputs: 28-bit mantissa and exponent.
  - Outputs: rounded 24-bit significand, adjusted exponent, and a carry-shift indication.
  - Instantiated in the ROUND stage.

## Test plan
- Normalized 1.0: sign=0, exp=127, mant=0x4000000. Expect res=0x3F800000, exception=0, out_valid 3 edges after accept.
- Carry case: exp=127, mant=0x8000000. Expect res=0x40000000, latency 3.
- Left shift: exp=127, mant=0x0800000 (L=3). Expect res=0x3E000000, latency 6, in_ready=0 throughout.
- RNE tie with carry: exp=127, mant=0x7FFFFFC. Expect res=0x40000000.
- Tie to even, no increment: exp=127, mant=0x4000004. Expect res=0x3F800000.
- Overflow: exp=254, mant=0x8000000. Expect res=0x7F800000, exception=1.
- Zero: sign=1, mant=0. Expect res=0x80000000, exception=0, latency 2.
- Underflow: exp=1, mant=0x2000000. Expect res=0x00000000, exception=1.
- Backpressure: out_ready=0 for 10 cycles, then 1. Expect res held stable; second job captured on the next cycle.
- reset asserted during NORM: out_valid never rises; in_ready=1 after reset.
